// File: rtl/data_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM state encoding and burst
// counter width, plus a saturating increment for the burst counter.
`timescale 1ns/1ps
package data_arb_pkg;

  typedef enum logic [1:0] {
    CPU_OWN   = 2'd0,
    DMA_OWN   = 2'd1,
    CPU_FORCE = 2'd2
  } arb_state_t;

  localparam int BURST_CNT_W = 4;

  function automatic logic [BURST_CNT_W-1:0] sat_inc(input logic [BURST_CNT_W-1:0] v);
    return (v == {BURST_CNT_W{1'b1}}) ? v : v + {{(BURST_CNT_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/data_mem_arbiter.sv
// Shares the data_memory port between the CPU data bus and a DMA/loader
// requester, stalling the CPU while it is locked out and bounding DMA bursts.
`timescale 1ns/1ps
module data_mem_arbiter
  import data_arb_pkg::*;
#(
  parameter int MAX_DMA_BURST = 4,
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sys_clk_enable,
  output logic              cpu_clk_enable,
  input  logic [ADDR_W-1:0] cpu_data_address,
  input  logic              cpu_data_write,
  input  logic              cpu_data_read,
  input  logic [DATA_W-1:0] cpu_data_writedata,
  output logic [DATA_W-1:0] cpu_data_readdata,
  input  logic              dma_req,
  input  logic              dma_write,
  input  logic [ADDR_W-1:0] dma_address,
  input  logic [DATA_W-1:0] dma_writedata,
  output logic              dma_ack,
  output logic [DATA_W-1:0] dma_readdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_write,
  output logic              mem_read,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata
);

  // Beat index (counter value before increment) on which a waiting CPU is forced in.
  localparam logic [BURST_CNT_W-1:0] LAST_BEAT = BURST_CNT_W'(MAX_DMA_BURST - 1);

  arb_state_t             state_q, state_d;
  logic [BURST_CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic                   cpu_req_s;
  logic                   dma_ack_s;
  logic                   mem_write_s;
  logic                   mem_read_s;

  assign cpu_req_s = cpu_data_read | cpu_data_write;

  // Next-state, burst counting and beat acknowledge.
  always_comb begin
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    dma_ack_s   = 1'b0;
    if (sys_clk_enable) begin
      case (state_q)
        CPU_OWN: begin
          if (dma_req && !cpu_req_s) begin
            state_d = DMA_OWN;
          end else begin
            state_d = CPU_OWN;
          end
          burst_cnt_d = {BURST_CNT_W{1'b0}};
        end
        DMA_OWN: begin
          if (dma_req) begin
            dma_ack_s = 1'b1;
            // >= rather than == so a saturated counter can never lock the CPU out.
            if ((burst_cnt_q >= LAST_BEAT) && cpu_req_s) begin
              state_d     = CPU_FORCE;
              burst_cnt_d = {BURST_CNT_W{1'b0}};
            end else begin
              state_d     = DMA_OWN;
              burst_cnt_d = sat_inc(burst_cnt_q);
            end
          end else begin
            state_d     = CPU_OWN;
            burst_cnt_d = {BURST_CNT_W{1'b0}};
          end
        end
        CPU_FORCE: begin
          if (dma_req) begin
            state_d = DMA_OWN;
          end else begin
            state_d = CPU_OWN;
          end
          burst_cnt_d = {BURST_CNT_W{1'b0}};
        end
        default: begin
          state_d     = CPU_OWN;
          burst_cnt_d = {BURST_CNT_W{1'b0}};
        end
      endcase
    end else begin
      state_d     = state_q;
      burst_cnt_d = burst_cnt_q;
    end
  end

  // State and burst counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= CPU_OWN;
      burst_cnt_q <= {BURST_CNT_W{1'b0}};
    end else begin
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  // Memory port mux: DMA only while it owns the port.
  always_comb begin
    mem_address   = cpu_data_address;
    mem_writedata = cpu_data_writedata;
    mem_write_s   = cpu_data_write;
    mem_read_s    = cpu_data_read;
    case (state_q)
      DMA_OWN: begin
        mem_address   = dma_address;
        mem_writedata = dma_writedata;
        mem_write_s   = dma_write & dma_req;
        mem_read_s    = ~dma_write & dma_req;
      end
      default: begin
        mem_address   = cpu_data_address;
        mem_writedata = cpu_data_writedata;
        mem_write_s   = cpu_data_write;
        mem_read_s    = cpu_data_read;
      end
    endcase
  end

  assign mem_write         = mem_write_s & ~reset;
  assign mem_read          = mem_read_s & ~reset;
  assign dma_ack           = dma_ack_s & ~reset;
  assign cpu_data_readdata = mem_readdata;
  assign dma_readdata      = mem_readdata;
  assign cpu_clk_enable    = sys_clk_enable & ~((state_q == DMA_OWN) & cpu_req_s);

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Shares the single data_memory port between the mips_cpu_harvard data port and a DMA/loader requester (bench preload, debug readback).
- Drives the CPU clk_enable so the CPU freezes while it has a pending data access that is not granted.
- Enforces a bounded DMA burst so the CPU cannot be starved.
- Sits between the CPU data bus and data_memory; the instruction path is untouched.

Parameters:
- MAX_DMA_BURST, 4: maximum consecutive DMA beats before the CPU is forced one grant cycle, if the CPU is requesting. Legal range 1..15.
- ADDR_W, 32: address width.
- DATA_W, 32: data width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- sys_clk_enable  in  1  global enable from the top; 0 freezes the arbiter and the CPU.
- cpu_clk_enable  out  1  clk_enable to the CPU.
- cpu_data_address  in  ADDR_W  CPU data address.
- cpu_data_write  in  1  CPU write strobe.
- cpu_data_read  in  1  CPU read strobe.
- cpu_data_writedata  in  DATA_W  CPU write data.
- cpu_data_readdata  out  DATA_W  read data returned to the CPU.
- dma_req  in  1  DMA wants one beat; held until dma_ack.
- dma_write  in  1  1 = write beat, 0 = read beat.
- dma_address  in  ADDR_W  DMA address.
- dma_writedata  in  DATA_W  DMA write data.
- dma_ack  out  1  single-cycle pulse; the beat completes this cycle.
- dma_readdata  out  DATA_W  read data, valid in the dma_ack cycle.
- mem_address  out  ADDR_W  to data_memory.
- mem_write  out  1  to data_memory.
- mem_read  out  1  to data_memory.
- mem_writedata  out  DATA_W  to data_memory.
- mem_readdata  in  DATA_W  from data_memory; combinational read, write on the rising edge.

Behaviour:
- cpu_req = cpu_data_read | cpu_data_write.
- FSM states: CPU_OWN, DMA_OWN, CPU_FORCE.
- Registered: state and the 4-bit burst counter burst_cnt.
- Output mux is combinational from state.
  - CPU_OWN or CPU_FORCE: mem_* follow the cpu_data_* inputs.
  - DMA_OWN: mem_address = dma_address, mem_write = dma_write & dma_req, mem_read = ~dma_write & dma_req.
- cpu_data_readdata and dma_readdata both carry mem_readdata.
- Reset (asynchronous): state = CPU_OWN, burst_cnt = 0. Outputs during reset:
  - cpu_clk_enable = sys_clk_enable;
  - dma_ack = 0;
  - mem_write = 0 and mem_read = 0 regardless of CPU strobes.
- Transitions, evaluated only when sys_clk_enable = 1; otherwise state and counter hold and dma_ack = 0:
  - CPU_OWN: dma_req & ~cpu_req goes to DMA_OWN. A CPU access always wins in CPU_OWN, so on simultaneous requests the CPU keeps its grant.
  - DMA_OWN: each cycle with dma_req = 1 is one beat; dma_ack = 1 and burst_cnt increments.
    - If burst_cnt + 1 == MAX_DMA_BURST and cpu_req: go to CPU_FORCE, burst_cnt = 0.
    - If dma_req = 0: go to CPU_OWN, burst_cnt = 0.
    - Otherwise stay in DMA_OWN.
  - CPU_FORCE: exactly one cycle; the CPU is granted. Go to DMA_OWN if dma_req, else CPU_OWN.
- cpu_clk_enable:
  - Equals sys_clk_enable & ~(state == DMA_OWN & cpu_req).
  - The CPU is stalled only while it is requesting and not granted; its strobes stay stable because it is frozen.
  - In DMA_OWN with cpu_req = 0 the CPU keeps running. It is on the instruction fetch path only, and mem_* still carry DMA.
- DMA write timing: memory is updated at the rising edge that ends the dma_ack cycle.
- DMA read data: dma_readdata is sampled by the requester in the same cycle as dma_ack.
- Reset mid-burst: an in-flight beat is dropped (no ack) and the requester must re-issue it. burst_cnt clears.
- burst_cnt saturates; it never wraps, since MAX_DMA_BURST ≤ 15.

Decomposition:
- Package data_arb_pkg:
  - typedef enum logic[1:0] arb_state_t {CPU_OWN, DMA_OWN, CPU_FORCE};
  - localparam BURST_CNT_W = 4.
- No sub-module. The output mux is inline; the FSM and counter live in one always_ff.

Test Plan:
- Reset held, CPU asserting cpu_data_write -> mem_write = 0, dma_ack = 0. After reset falls, mem_address = cpu_data_address.
- CPU idle, DMA writes 32'hDEADBEEF to 0x10, then reads 0x10 -> two dma_ack pulses on consecutive cycles; the read returns 32'hDEADBEEF; cpu_clk_enable stays 1 throughout.
- CPU and DMA both request in CPU_OWN -> the CPU is granted and dma_ack = 0. When cpu_req drops, the DMA is acked the next cycle.
- DMA holds dma_req for 10 beats with MAX_DMA_BURST = 4 while the CPU issues a write:
  - required ack pattern: 4 acks, 1 CPU_FORCE cycle, 4 acks, 1 CPU_FORCE cycle, 2 acks;
  - cpu_clk_enable = 0 only during DMA_OWN cycles where cpu_req = 1.
- sys_clk_enable = 0 during DMA_OWN -> no dma_ack, state and burst_cnt frozen, cpu_clk_enable = 0. The burst resumes when the enable returns.
- Assert reset on the 2nd beat of a burst -> no ack that cycle, state = CPU_OWN, burst_cnt = 0, and the CPU access proceeds after release.
